// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: issues word reads at the PC and buffers responses for decode.
// Optional feature macro: IFU_HALT_ON_ZERO_EN (stop fetching on a zero instruction word).
module instr_fetch_unit #(
    parameter int unsigned         ADDR_W   = 5,
    parameter int unsigned         DEPTH    = 2,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              halted_q;
    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    demand;
    logic              has_head;
    logic              pop;
    logic              push;
    logic              issue;
    logic              zero_word;

    // Handshake and head presentation; a head shown during redirect is never consumed.
    assign has_head    = (occ != '0);
    assign instr_valid = has_head & ~redirect_valid;
    assign instr_data  = has_head ? data_q[rd_ptr] : 32'h0;
    assign instr_pc    = has_head ? tag_q[rd_ptr] : '0;
    assign pop         = instr_valid & instr_ready;

    // Entries committed after this cycle, counting the response still on its way.
    assign demand = {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);
    assign issue  = ~reset & ~redirect_valid & ~halted_q & (demand < (OCC_W + 1)'(DEPTH));

    assign mem_read  = issue;
    assign mem_write = 1'b0;
    assign mem_addr  = pc;
    assign halted    = halted_q;

`ifdef IFU_HALT_ON_ZERO_EN
    assign zero_word = (mem_rdata == 32'h0);

    // Halt latches on a captured zero word; only redirect or reset releases it.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            halted_q <= 1'b0;
        end else if (inflight && !halted_q && zero_word) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign zero_word = 1'b0;
    assign halted_q  = 1'b0;
`endif

    assign push = inflight & ~halted_q & ~zero_word & ~redirect_valid & ~reset;

    // PC, request tracking and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (issue) begin
                pc     <= pc + ADDR_W'(4);
                req_pc <= pc;
            end
            inflight <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // FIFO storage needs no reset: empty entries are masked at the head.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= mem_rdata;
            tag_q[wr_ptr]  <= req_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (occ == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=4, ADDR_W=5) with a registered-read memory model.
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          halted;

    logic [31:0]   mem [8];
    int            checks;
    int            failures;

    instr_fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(5'd0)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read port: data appears the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[4:2]];
    end

    function automatic logic [31:0] word_at(int i);
        if (i == 0) return 32'h00430820;
        if (i == 1) return 32'h20410004;
        return 32'hA000_0000 | 32'(i * 4);
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 8; i++) mem[i] = word_at(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at #1 into the first cycle after reset deasserts.
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        step(); step(); #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        checks++; if (mem_addr !== 5'd0) begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", instr_data); end
        checks++; if (instr_pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", instr_pc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_fetch();
        init_mem(); instr_ready = 1'b1;
        do_reset(); #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin step(); #1; end
            checks++; if (mem_read !== 1'b1 || mem_addr !== 5'(4 * k))
                begin failures++; $display("FAIL fetch_issue c%0d got=%b/%0d exp=1/%0d", k, mem_read, mem_addr, 4 * k); end
            if (k < 2) begin
                checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL fetch_fill c%0d valid=%b exp=0", k, instr_valid); end
            end else begin
                checks++; if (instr_valid !== 1'b1 || instr_data !== word_at(k - 2) || instr_pc !== 5'(4 * (k - 2)))
                    begin failures++; $display("FAIL fetch_head c%0d got=%b/%h/%0d exp=1/%h/%0d", k, instr_valid, instr_data, instr_pc, word_at(k - 2), 4 * (k - 2)); end
            end
        end
    endtask

    task automatic test_backpressure();
        init_mem(); instr_ready = 1'b0;
        do_reset(); #1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin step(); #1; end
            checks++; if (mem_read !== (k < 4))
                begin failures++; $display("FAIL bp_mem_read c%0d got=%b exp=%b", k, mem_read, (k < 4)); end
        end
        checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h00430820 || instr_pc !== 5'd0 || mem_addr !== 5'd16)
            begin failures++; $display("FAIL bp_hold got=%b/%h/%0d addr=%0d exp=1/00430820/0 addr=16", instr_valid, instr_data, instr_pc, mem_addr); end
        step();
        instr_ready = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 5'd16)
            begin failures++; $display("FAIL bp_resume got=%b/%0d exp=1/16", mem_read, mem_addr); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin step(); #1; end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'(4 * i) || instr_data !== word_at(i))
                begin failures++; $display("FAIL bp_drain i%0d got=%b/%0d/%h exp=1/%0d/%h", i, instr_valid, instr_pc, instr_data, 4 * i, word_at(i)); end
        end
    endtask

    task automatic test_redirect();
        init_mem(); instr_ready = 1'b0;
        do_reset(); step(); step(); step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0)
            begin failures++; $display("FAIL redir_pre got=%b/%0d exp=1/0", instr_valid, instr_pc); end
        redirect_valid = 1'b1; redirect_pc = 5'd20;
        #1;
        checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0)
            begin failures++; $display("FAIL redir_cycle valid/read got=%b/%b exp=0/0", instr_valid, mem_read); end
        step();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 5'd20)
            begin failures++; $display("FAIL redir_r1 got=%b/%b/%0d exp=0/1/20", instr_valid, mem_read, mem_addr); end
        step(); #1;
        checks++; if (instr_valid !== 1'b0 || mem_addr !== 5'd24)
            begin failures++; $display("FAIL redir_r2 got=%b/%0d exp=0/24", instr_valid, mem_addr); end
        step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd20 || instr_data !== word_at(5))
            begin failures++; $display("FAIL redir_r3 got=%b/%0d/%h exp=1/20/%h", instr_valid, instr_pc, instr_data, word_at(5)); end
        step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd24)
            begin failures++; $display("FAIL redir_r4 got=%b/%0d exp=1/24", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 5'd24; exp_addr[1] = 5'd28; exp_addr[2] = 5'd0; exp_addr[3] = 5'd4;
        init_mem(); instr_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 5'd26;
        #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL wrap_redir_read got=%b exp=0", mem_read); end
        step();
        redirect_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin step(); #1; end
            checks++; if (mem_read !== 1'b1 || mem_addr !== exp_addr[k])
                begin failures++; $display("FAIL wrap_addr k%0d got=%b/%0d exp=1/%0d", k, mem_read, mem_addr, exp_addr[k]); end
            if (k >= 2) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_addr[k - 2] || instr_data !== word_at(int'(exp_addr[k - 2]) / 4))
                    begin failures++; $display("FAIL wrap_head k%0d got=%b/%0d/%h exp=1/%0d", k, instr_valid, instr_pc, instr_data, exp_addr[k - 2]); end
            end
        end
    endtask

    task automatic test_zero_word();
        init_mem(); mem[2] = 32'h0; instr_ready = 1'b1;
        do_reset(); step(); step(); step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd4 || halted !== 1'b0)
            begin failures++; $display("FAIL zero_pre got=%b/%0d halted=%b exp=1/4 halted=0", instr_valid, instr_pc, halted); end
`ifdef IFU_HALT_ON_ZERO_EN
        for (int k = 4; k < 8; k++) begin
            step(); #1;
            checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_read !== 1'b0)
                begin failures++; $display("FAIL halt_hold c%0d got=h%b/v%b/r%b exp=h1/v0/r0", k, halted, instr_valid, mem_read); end
        end
        step();
        redirect_valid = 1'b1; redirect_pc = 5'd0;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 5'd0)
            begin failures++; $display("FAIL halt_release got=h%b/r%b/%0d exp=h0/r1/0", halted, mem_read, mem_addr); end
        step(); step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr_data !== word_at(0))
            begin failures++; $display("FAIL halt_restart got=%b/%0d/%h exp=1/0/%h", instr_valid, instr_pc, instr_data, word_at(0)); end
`else
        step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd8 || instr_data !== 32'h0 || halted !== 1'b0)
            begin failures++; $display("FAIL zero_deliver got=%b/%0d/%h halted=%b exp=1/8/0 halted=0", instr_valid, instr_pc, instr_data, halted); end
        step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd12 || instr_data !== word_at(3))
            begin failures++; $display("FAIL zero_next got=%b/%0d/%h exp=1/12/%h", instr_valid, instr_pc, instr_data, word_at(3)); end
`endif
    endtask

    task automatic test_reset_mid();
        init_mem(); instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL mid_reset_read got=%b exp=0", mem_read); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (mem_addr !== 5'd0 || mem_read !== 1'b1 || instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 5'd0 || halted !== 1'b0)
            begin failures++; $display("FAIL mid_reset_state got=a%0d/r%b/v%b/%h/%0d/h%b exp=a0/r1/v0/0/0/h0", mem_addr, mem_read, instr_valid, instr_data, instr_pc, halted); end
        step(); #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_drop got=%b exp=0", instr_valid); end
        step(); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr_data !== word_at(0))
            begin failures++; $display("FAIL mid_reset_restart got=%b/%0d/%h exp=1/0/%h", instr_valid, instr_pc, instr_data, word_at(0)); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        init_mem();
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_zero_word();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
